// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: counter sizing and the wrapping pointer increment
// used by FIFOs whose depth need not be a power of two.
package fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Wraps at depth-1 -> 0 explicitly; natural overflow is only correct for 2**n depths.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_level_mem.sv
// Storage array for fifo_level: synchronous write, asynchronous read, no reset.
module fifo_level_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 5,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_level.sv
// Single-clock FIFO of any depth >= 2 with occupancy count, registered
// almost-full/almost-empty flags, synchronous flush and a high-water mark.
module fifo_level
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 5,
  parameter  int AF_LEVEL   = DEPTH - 1,
  parameter  int AE_LEVEL   = 1,
  localparam int CNT_W      = cnt_width(DEPTH),
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush_i,
  input  logic                  hwm_clear_i,
  input  logic                  push_valid_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic                  push_grant_o,
  output logic                  pop_valid_o,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  input  logic                  pop_grant_i,
  output logic [CNT_W-1:0]      level_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CNT_W-1:0]      hwm_o
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_level: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_level: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("fifo_level: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  hwm_q, hwm_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              push_fire, pop_fire;

  // Handshake: a transfer fires only when valid and grant are both high on
  // the same rising edge; grants depend solely on the registered level.
  assign push_grant_o = (level_q != CNT_W'(DEPTH));
  assign pop_valid_o  = (level_q != '0);
  assign push_fire    = push_valid_i & push_grant_o;
  assign pop_fire     = pop_valid_o & pop_grant_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = ADDR_W'(ptr_inc(32'(wr_ptr_q), 32'(DEPTH)));
      if (pop_fire)  rd_ptr_d = ADDR_W'(ptr_inc(32'(rd_ptr_q), 32'(DEPTH)));
      case ({push_fire, pop_fire})
        2'b10:   level_d = level_q + CNT_W'(1);
        2'b01:   level_d = level_q - CNT_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Flags and the mark look at the next level so they line up with level_o.
  always_comb begin
    af_d = (level_d >= CNT_W'(AF_LEVEL));
    ae_d = (level_d <= CNT_W'(AE_LEVEL));
    if (flush_i)          hwm_d = '0;
    else if (hwm_clear_i) hwm_d = level_d;
    else                  hwm_d = (level_d > hwm_q) ? level_d : hwm_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hwm_q    <= '0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hwm_q    <= hwm_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  fifo_level_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_fire & ~flush_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (push_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (pop_data_o)
  );

  assign level_o        = level_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign hwm_o          = hwm_q;

endmodule

// File: tb/tb_fifo_level.sv
// Randomised and directed bench for fifo_level against a queue-based model.
module tb_fifo_level;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush_i, hwm_clear_i, push_valid_i, pop_grant_i;
  logic [DW-1:0] push_data_i;
  logic          push_grant_o, pop_valid_o, almost_full_o, almost_empty_o;
  logic [DW-1:0] pop_data_o;
  logic [CW-1:0] level_o, hwm_o;

  int checks = 0;
  int errors = 0;

  // Model state: exp_q is the FIFO contents, oldest first.
  logic [DW-1:0] exp_q[$];
  int            m_level = 0;
  int            m_hwm   = 0;

  fifo_level #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush_i        (flush_i),
    .hwm_clear_i    (hwm_clear_i),
    .push_valid_i   (push_valid_i),
    .push_data_i    (push_data_i),
    .push_grant_o   (push_grant_o),
    .pop_valid_o    (pop_valid_o),
    .pop_data_o     (pop_data_o),
    .pop_grant_i    (pop_grant_i),
    .level_o        (level_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .hwm_o          (hwm_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model update: follows the transfer rules on every accepting edge.
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        exp_q.delete();
        m_level = 0;
        m_hwm   = 0;
      end else begin
        bit pf, qf;
        pf = push_valid_i && (m_level < DEPTH);
        qf = pop_grant_i && (m_level > 0);
        if (flush_i) begin
          exp_q.delete();
          m_level = 0;
          m_hwm   = 0;
        end else begin
          if (pf) exp_q.push_back(push_data_i);
          m_level = m_level + int'(pf) - int'(qf);
          if (hwm_clear_i)        m_hwm = m_level;
          else if (m_level > m_hwm) m_hwm = m_level;
        end
      end
    end
  end

  // Monitor: compares outputs mid-cycle and retires popped words.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("level",        int'(level_o),        m_level);
        chk("push_grant",   int'(push_grant_o),   int'(m_level < DEPTH));
        chk("pop_valid",    int'(pop_valid_o),    int'(m_level > 0));
        chk("almost_full",  int'(almost_full_o),  int'(m_level >= AF));
        chk("almost_empty", int'(almost_empty_o), int'(m_level <= AE));
        chk("hwm",          int'(hwm_o),          m_hwm);
        if (pop_valid_o) begin
          if (exp_q.size() == 0) begin
            chk("pop_underflow", 1, 0);
          end else begin
            chk("pop_data", int'(pop_data_o), int'(exp_q[0]));
            if (pop_grant_i && !flush_i) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc(input bit pv, input logic [DW-1:0] pd, input bit pg,
                     input bit fl = 1'b0, input bit hc = 1'b0);
    push_valid_i = pv;
    push_data_i  = pd;
    pop_grant_i  = pg;
    flush_i      = fl;
    hwm_clear_i  = hc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
  endtask

  logic [DW-1:0] seq;

  initial begin
    reset_n      = 1'b0;
    flush_i      = 1'b0;
    hwm_clear_i  = 1'b0;
    push_valid_i = 1'b0;
    pop_grant_i  = 1'b0;
    push_data_i  = '0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    chk("rst_level",  int'(level_o),        0);
    chk("rst_grant",  int'(push_grant_o),   1);
    chk("rst_pvalid", int'(pop_valid_o),    0);
    chk("rst_af",     int'(almost_full_o),  0);
    chk("rst_ae",     int'(almost_empty_o), 1);
    chk("rst_hwm",    int'(hwm_o),          0);
    @(posedge clk);
    #1;

    // Fill to full with one refused extra push, then drain in order.
    for (int i = 0; i < 6; i++) cyc(1'b1, DW'(8'h10 + i), 1'b0);
    chk("full_level", int'(level_o), DEPTH);
    chk("full_grant", int'(push_grant_o), 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);
    chk("drained", int'(level_o), 0);

    // Wrap the non-power-of-two pointers with a two-entry offset.
    seq = 8'h40;
    for (int i = 0; i < 2; i++) begin cyc(1'b1, seq, 1'b0); seq++; end
    for (int i = 0; i < 12; i++) begin cyc(1'b1, seq, 1'b1); seq++; end
    for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b1);

    // Steady level 3 with simultaneous traffic; flush first so hwm tracks 3.
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin cyc(1'b1, seq, 1'b0); seq++; end
    for (int i = 0; i < 10; i++) begin cyc(1'b1, seq, 1'b1); seq++; end
    chk("steady_level", int'(level_o), 3);
    chk("steady_hwm",   int'(hwm_o),   3);

    // Full boundary: only the pop can fire.
    for (int i = 0; i < 2; i++) begin cyc(1'b1, seq, 1'b0); seq++; end
    cyc(1'b1, 8'hEE, 1'b1);
    chk("fullb_level", int'(level_o), 4);
    chk("fullb_grant", int'(push_grant_o), 1);

    // Flush at level 4 while push and pop both fire.
    cyc(1'b1, 8'hAA, 1'b1, 1'b1);
    chk("flush_level",  int'(level_o),        0);
    chk("flush_pvalid", int'(pop_valid_o),    0);
    chk("flush_ae",     int'(almost_empty_o), 1);
    chk("flush_hwm",    int'(hwm_o),          0);
    idle(2);

    // High-water mark clear loads the current level.
    for (int i = 0; i < 5; i++) begin cyc(1'b1, seq, 1'b0); seq++; end
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
    chk("hwm_peak", int'(hwm_o), 5);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("hwm_clear", int'(hwm_o), 2);

    // Random traffic with occasional flush and hwm clear.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 60), DW'($urandom_range(0, 255)),
          ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 3),
          ($urandom_range(0, 99) < 5));
    end

    // Asynchronous reset in the middle of a push cycle.
    cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(8'h70 + i), 1'b0);
    push_valid_i = 1'b1;
    push_data_i  = 8'h7F;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_level",  int'(level_o),        0);
    chk("arst_grant",  int'(push_grant_o),   1);
    chk("arst_pvalid", int'(pop_valid_o),    0);
    chk("arst_af",     int'(almost_full_o),  0);
    chk("arst_ae",     int'(almost_empty_o), 1);
    chk("arst_hwm",    int'(hwm_o),          0);
    push_valid_i = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) cyc(1'b1, DW'(8'h90 + i), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
